// File: rtl/lfsr_bist_ctl.sv
// lfsr_bist_ctl -- LFSR stimulus / signature-response BIST controller.
//
// Drives a 64-bit LFSR pattern stream into a combinational DUT over a
// valid/ready handshake, captures the DUT's 9-bit responses, and folds a
// window of them (skipping the first SKIP, then COUNT words) into a 32-bit
// rotate-XOR signature. The result is compared against EXPECT.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   start      single-cycle run request (honoured in IDLE/DONE only)
//   pat_data   pattern word, always lfsr[8:0]
//   pat_valid  pattern word available (RUN state)
//   pat_ready  DUT accepts the pattern word
//   rsp_data   DUT response word
//   rsp_valid  response present (no backpressure)
//   busy       run in progress (RUN or DRAIN)
//   done       run finished, held until next start
//   pass       signature == EXPECT and no timeout, valid while done
//   timeout    run ended because responses stopped arriving
//   signature  current signature register
module lfsr_bist_ctl #(
   parameter logic [63:0] SEED    = 64'h5aef0c8d_d70a4497,
   parameter int unsigned SKIP    = 11,
   parameter int unsigned COUNT   = 79,
   parameter logic [31:0] EXPECT  = 32'he8bbd130,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [8:0]  pat_data,
   output logic        pat_valid,
   input  logic        pat_ready,
   input  logic [8:0]  rsp_data,
   input  logic        rsp_valid,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] signature
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [15:0] TOTAL      = 16'(SKIP + COUNT);
   localparam logic [15:0] TOTAL_M1   = TOTAL - 16'd1;
   localparam logic [16:0] SKIP_W     = 17'(SKIP);
   localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT) - 16'd1;

   logic [1:0]  state;
   logic [63:0] lfsr;
   logic [31:0] sig;
   logic [15:0] tx_cnt;
   logic [15:0] rx_cnt;
   logic [15:0] idle_cnt;
   logic        timeout_q;

   logic [63:0] lfsr_next;
   logic [31:0] sig_next;
   logic        in_window;

   assign lfsr_next = {lfsr[62:0], lfsr[63] ^ lfsr[2] ^ lfsr[0]};
   assign sig_next  = {sig[30:0], sig[31]} ^ {23'h0, rsp_data};

   // SKIP <= rx_cnt written as rx_cnt+1 > SKIP in 17 bits so that a SKIP of
   // zero does not collapse into an always-true unsigned compare.
   assign in_window = ((17'(rx_cnt) + 17'd1) > SKIP_W) && (rx_cnt < TOTAL);

   // NOTE: sequential state uses non-blocking assignments only; later
   // assignments to 'state' in the same edge deliberately override earlier
   // ones, which is how the final-response transition wins over RUN->DRAIN.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lfsr      <= SEED;
         sig       <= 32'h0;
         tx_cnt    <= 16'h0;
         rx_cnt    <= 16'h0;
         idle_cnt  <= 16'h0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  lfsr      <= SEED;
                  sig       <= 32'h0;
                  tx_cnt    <= 16'h0;
                  rx_cnt    <= 16'h0;
                  idle_cnt  <= 16'h0;
                  timeout_q <= 1'b0;
                  state     <= RUN;
               end
            end
            RUN, DRAIN: begin
               if (state == RUN && pat_ready) begin
                  lfsr   <= lfsr_next;
                  tx_cnt <= tx_cnt + 16'd1;
                  if (tx_cnt == TOTAL_M1) state <= DRAIN;
               end
               if (state == DRAIN) begin
                  if (rsp_valid) begin
                     idle_cnt <= 16'h0;
                  end else begin
                     idle_cnt <= idle_cnt + 16'd1;
                     if (idle_cnt == TIMEOUT_M1) begin
                        state     <= DONE;
                        timeout_q <= 1'b1;
                     end
                  end
               end
               if (rsp_valid) begin
                  if (in_window) sig <= sig_next;
                  rx_cnt <= rx_cnt + 16'd1;
                  if (rx_cnt == TOTAL_M1) state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign pat_data  = lfsr[8:0];
   assign pat_valid = (state == RUN);
   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);
   assign timeout   = timeout_q;
   assign pass      = done && (sig == EXPECT) && !timeout_q;
   assign signature = sig;

endmodule

// File: tb/tb_lfsr_bist_ctl.sv
// Testbench for lfsr_bist_ctl.
// Instances a/b use a tiny configuration (SEED=1, SKIP=0, COUNT=3,
// TIMEOUT=4) driven from a cycle table; b differs only in EXPECT so it never
// passes. Instance c uses the default parameters and is exercised by
// hand-written runs (ready held high, ready toggling, reset mid-run).
module tb_lfsr_bist_ctl;

   typedef struct packed {
      logic        pv;
      logic [8:0]  pd;
      logic        busy;
      logic        done;
      logic        pass;
      logic        to;
      logic [31:0] sig;
   } outs_t;

   typedef struct {
      logic  start;
      logic  ready;
      logic  en;
      logic  frc;
      outs_t exp;
   } vec_t;

   localparam logic [63:0] DEF_SEED   = 64'h5aef0c8d_d70a4497;
   localparam logic [31:0] DEF_EXPECT = 32'he8bbd130;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int stall_err = 0;

   // shared table-driven stimulus for a and b
   logic t_start = 1'b0;
   logic t_ready = 1'b0;
   logic t_en    = 1'b0;
   logic t_frc   = 1'b0;

   // instance a
   logic [8:0]  a_pd, a_rd;
   logic        a_pv, a_rv, a_busy, a_done, a_pass, a_to;
   logic [31:0] a_sig;
   outs_t       a_out;
   assign a_rv  = (a_pv & t_ready & t_en) | t_frc;
   assign a_rd  = t_frc ? 9'h1ff : a_pd;
   assign a_out = {a_pv, a_pd, a_busy, a_done, a_pass, a_to, a_sig};

   lfsr_bist_ctl #(.SEED(64'h1), .SKIP(0), .COUNT(3), .EXPECT(32'h5), .TIMEOUT(4)) dut_a (
      .clk(clk), .reset(reset), .start(t_start),
      .pat_data(a_pd), .pat_valid(a_pv), .pat_ready(t_ready),
      .rsp_data(a_rd), .rsp_valid(a_rv),
      .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_to), .signature(a_sig)
   );

   // instance b
   logic [8:0]  b_pd, b_rd;
   logic        b_pv, b_rv, b_busy, b_done, b_pass, b_to;
   logic [31:0] b_sig;
   outs_t       b_out;
   assign b_rv  = (b_pv & t_ready & t_en) | t_frc;
   assign b_rd  = t_frc ? 9'h1ff : b_pd;
   assign b_out = {b_pv, b_pd, b_busy, b_done, b_pass, b_to, b_sig};

   lfsr_bist_ctl #(.SEED(64'h1), .SKIP(0), .COUNT(3), .EXPECT(32'h6), .TIMEOUT(4)) dut_b (
      .clk(clk), .reset(reset), .start(t_start),
      .pat_data(b_pd), .pat_valid(b_pv), .pat_ready(t_ready),
      .rsp_data(b_rd), .rsp_valid(b_rv),
      .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_to), .signature(b_sig)
   );

   // instance c, default parameters, identity loopback
   logic        c_start = 1'b0;
   logic        c_ready = 1'b0;
   logic [8:0]  c_pd;
   logic        c_pv, c_busy, c_done, c_pass, c_to;
   logic [31:0] c_sig;
   outs_t       c_out;
   assign c_out = {c_pv, c_pd, c_busy, c_done, c_pass, c_to, c_sig};

   lfsr_bist_ctl dut_c (
      .clk(clk), .reset(reset), .start(c_start),
      .pat_data(c_pd), .pat_valid(c_pv), .pat_ready(c_ready),
      .rsp_data(c_pd), .rsp_valid(c_pv & c_ready),
      .busy(c_busy), .done(c_done), .pass(c_pass), .timeout(c_to), .signature(c_sig)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic rd, input logic en, input logic fr,
                               input logic pv, input logic [8:0] pd, input logic bsy,
                               input logic dn, input logic ps, input logic to,
                               input logic [31:0] sg);
      vec_t v;
      v.start = st; v.ready = rd; v.en = en; v.frc = fr;
      v.exp = {pv, pd, bsy, dn, ps, to, sg};
      return v;
   endfunction

   // Reference signature for the default configuration with identity
   // loopback: response i is pattern i.
   function automatic logic [31:0] model_sig();
      logic [63:0] l;
      logic [31:0] s;
      l = DEF_SEED;
      s = 32'h0;
      for (int i = 0; i < 90; i++) begin
         if (i >= 11) s = {s[30:0], s[31]} ^ {23'h0, l[8:0]};
         l = {l[62:0], l[63] ^ l[2] ^ l[0]};
      end
      return s;
   endfunction

   // One complete run on c; ready held high or toggling every cycle.
   task automatic run_c(input string tag, input bit toggle, input logic [31:0] ref_sig,
                        output logic [31:0] sig_out);
      logic       stalled;
      logic [8:0] held;
      bit         fin;
      @(negedge clk);
      c_start = 1'b1;
      c_ready = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      stalled = 1'b0;
      held    = 9'h0;
      fin     = 1'b0;
      for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
         c_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
         #1;
         if (stalled && c_pv && (c_pd != held)) stall_err++;
         stalled = c_pv & ~c_ready;
         held    = c_pd;
         if (c_done) fin = 1'b1;
         else @(negedge clk);
      end
      check({tag, "_finished"}, 64'(fin), 64'd1);
      check({tag, "_sig"}, 64'(c_sig), 64'(ref_sig));
      check({tag, "_timeout"}, 64'(c_to), 64'd0);
      check({tag, "_pass"}, 64'(c_pass), 64'(ref_sig == DEF_EXPECT));
      sig_out = c_sig;
   endtask

   vec_t        vecs[22];
   logic [31:0] model, sig_hi, sig_tog, sig_rst;
   outs_t       rst_vals;

   initial begin
      // start/ready/en/frc | pv pd busy done pass to sig
      vecs[0]  = mk(0,1,1,1, 0,9'h001,0,0,0,0,32'h0);  // response forced in IDLE
      vecs[1]  = mk(1,1,1,0, 0,9'h001,0,0,0,0,32'h0);
      vecs[2]  = mk(0,1,1,0, 1,9'h001,1,0,0,0,32'h0);
      vecs[3]  = mk(0,1,1,0, 1,9'h003,1,0,0,0,32'h1);
      vecs[4]  = mk(0,1,1,0, 1,9'h007,1,0,0,0,32'h1);
      vecs[5]  = mk(0,1,1,0, 0,9'h00e,0,1,1,0,32'h5);
      vecs[6]  = mk(0,0,1,1, 0,9'h00e,0,1,1,0,32'h5);  // response forced in DONE
      vecs[7]  = mk(1,1,1,0, 0,9'h00e,0,1,1,0,32'h5);
      vecs[8]  = mk(0,1,1,0, 1,9'h001,1,0,0,0,32'h0);
      vecs[9]  = mk(0,0,1,0, 1,9'h003,1,0,0,0,32'h1);  // stall
      vecs[10] = mk(0,1,1,0, 1,9'h003,1,0,0,0,32'h1);
      vecs[11] = mk(0,1,0,0, 1,9'h007,1,0,0,0,32'h1);  // responses stop
      vecs[12] = mk(0,1,0,0, 0,9'h00e,1,0,0,0,32'h1);
      vecs[13] = mk(0,1,0,0, 0,9'h00e,1,0,0,0,32'h1);
      vecs[14] = mk(0,1,0,0, 0,9'h00e,1,0,0,0,32'h1);
      vecs[15] = mk(0,1,0,0, 0,9'h00e,1,0,0,0,32'h1);
      vecs[16] = mk(0,1,0,0, 0,9'h00e,0,1,0,1,32'h1);  // timed out
      vecs[17] = mk(1,1,1,0, 0,9'h00e,0,1,0,1,32'h1);
      vecs[18] = mk(1,1,1,0, 1,9'h001,1,0,0,0,32'h0);  // start ignored in RUN
      vecs[19] = mk(1,1,1,0, 1,9'h003,1,0,0,0,32'h1);
      vecs[20] = mk(0,1,1,0, 1,9'h007,1,0,0,0,32'h1);
      vecs[21] = mk(0,1,1,0, 0,9'h00e,0,1,1,0,32'h5);

      rst_vals = {1'b0, DEF_SEED[8:0], 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      model    = model_sig();

      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("c_reset_values", 64'(c_out), 64'(rst_vals));

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         t_start = vecs[i].start;
         t_ready = vecs[i].ready;
         t_en    = vecs[i].en;
         t_frc   = vecs[i].frc;
         #1;
         check($sformatf("a_row%0d", i), 64'(a_out), 64'(vecs[i].exp));
         begin
            outs_t eb;
            eb = vecs[i].exp;
            eb.pass = 1'b0;
            check($sformatf("b_row%0d", i), 64'(b_out), 64'(eb));
         end
      end
      @(negedge clk);
      t_start = 1'b0;
      t_en    = 1'b0;
      t_frc   = 1'b0;

      run_c("c_ready_high", 1'b0, model, sig_hi);
      run_c("c_ready_toggle", 1'b1, model, sig_tog);
      check("c_toggle_vs_high", 64'(sig_tog), 64'(sig_hi));
      check("c_stall_stable", 64'(stall_err), 64'd0);

      // reset in the middle of a run, then a clean run
      @(negedge clk);
      c_start = 1'b1;
      c_ready = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("c_midrun_busy", 64'(c_busy), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("c_midrun_reset_values", 64'(c_out), 64'(rst_vals));
      run_c("c_after_reset", 1'b0, model, sig_rst);
      check("c_after_reset_vs_clean", 64'(sig_rst), 64'(sig_hi));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
